// File: rtl/mem_pkg.sv
// Shared types and constants for the memory fill responder: FSM states,
// request direction encoding and block/word geometry.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int WORD_W          = 32;
    localparam int WORD_BYTES      = 4;
    localparam int BLOCK_BYTES_C   = 8;
    localparam int WORDS_PER_BLOCK = BLOCK_BYTES_C / WORD_BYTES;

    // Wide enough for any LATENCY in 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_word_array.sv
// Backing store of 32-bit words: combinational read of an aligned word pair,
// synchronous halfword write. Contents are deliberately not reset.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_hi,
    input  logic [15:0]      wr_half,
    input  logic [IDX_W-2:0] rd_pair,
    output logic [63:0]      rd_data
);

    logic [WORD_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wr_hi) begin
                mem[wr_idx][31:16] <= wr_half;
            end else begin
                mem[wr_idx][15:0] <= wr_half;
            end
        end
    end

    assign rd_data = {mem[{rd_pair, 1'b1}], mem[{rd_pair, 1'b0}]};

endmodule

// File: rtl/mem_fill_responder.sv
// Block-fill memory responder: accepts one read-block or write-halfword request,
// answers LATENCY cycles later. Define MEM_FILL_STATS_EN to add traffic counters.
module mem_fill_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_BYTES = 8,
    parameter int MEM_WORDS   = 1024,
    parameter int LATENCY     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output state_t            state
`ifdef MEM_FILL_STATS_EN
    ,
    output logic [31:0]       stat_reads,
    output logic [31:0]       stat_writes,
    output logic [31:0]       stat_stall
`endif
);

    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W:0]  WORD_LIMIT = (ADDR_W + 1)'(MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);

    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              cap_rw;
    logic [ADDR_W-1:1] cap_addr;
    logic [15:0]       cap_wdata;
    logic              addr_unused;

    logic [ADDR_W:0]   rd_last_word;
    logic [ADDR_W:0]   wr_word;
    logic              rd_err;
    logic              wr_err;
    logic              xact_err;
    logic              commit;
    logic              mem_we;
    logic [63:0]       rd_data;

    // Byte-within-halfword bit never selects anything.
    assign addr_unused = req_addr[0];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Range checks use the highest word touched, widened so nothing wraps.
    assign rd_last_word = {{OFF_W{1'b0}}, cap_addr[ADDR_W-1:OFF_W], 1'b1};
    assign wr_word      = {3'b000, cap_addr[ADDR_W-1:2]};
    assign rd_err       = (rd_last_word >= WORD_LIMIT);
    assign wr_err       = (wr_word >= WORD_LIMIT);
    assign xact_err     = (cap_rw == READ) ? rd_err : wr_err;

    assign commit = (state == WAIT) && (cnt == '0);
    assign mem_we = commit && (cap_rw == WRITE) && !wr_err;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = WAIT;
            WAIT:    if (cnt == '0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_rw    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && req_valid) begin
                cap_rw    <= req_rw;
                cap_addr  <= req_addr[ADDR_W-1:1];
                cap_wdata <= req_wdata;
                cnt       <= CNT_LOAD;
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (commit) begin
                rsp_err   <= xact_err;
                rsp_rdata <= ((cap_rw == READ) && !xact_err) ? rd_data : '0;
            end
        end
    end

    mem_word_array #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (mem_we),
        .wr_idx  (cap_addr[IDX_W+1:2]),
        .wr_hi   (cap_addr[1]),
        .wr_half (cap_wdata),
        .rd_pair (cap_addr[OFF_W+IDX_W-2:OFF_W]),
        .rd_data (rd_data)
    );

`ifdef MEM_FILL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_stall  <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (cap_rw == READ) begin
                    stat_reads <= stat_reads + 32'd1;
                end else begin
                    stat_writes <= stat_writes + 32'd1;
                end
            end
            if (rsp_valid && !rsp_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed bench for mem_fill_responder with a reference memory model and an
// expected-response queue; covers MEM_FILL_STATS_EN counters when defined.
module tb_mem_fill_responder;
    import mem_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 1024;
    localparam int LATENCY   = 4;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [63:0]       rsp_rdata;
    logic              rsp_err;
    state_t            state;
`ifdef MEM_FILL_STATS_EN
    logic [31:0]       stat_reads;
    logic [31:0]       stat_writes;
    logic [31:0]       stat_stall;
`endif

    mem_fill_responder #(
        .ADDR_W      (ADDR_W),
        .BLOCK_BYTES (8),
        .MEM_WORDS   (MEM_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .state       (state)
`ifdef MEM_FILL_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_stall  (stat_stall)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          rd_count    = 0;
    int          wr_count    = 0;
    time         acc_time;
    logic [64:0] exp_q[$];
    logic [31:0] model_mem [0:MEM_WORDS-1];

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model: returns {err, rdata} and applies in-range writes
    function automatic logic [64:0] model_apply(input logic rw, input logic [31:0] addr,
                                                input logic [15:0] wd);
        int unsigned idx;
        if (rw) begin
            idx = (addr >> 3) * 2;
            if (idx + 1 >= MEM_WORDS) return {1'b1, 64'h0};
            return {1'b0, model_mem[idx+1], model_mem[idx]};
        end
        idx = addr >> 2;
        if (idx >= MEM_WORDS) return {1'b1, 64'h0};
        if (addr[1]) model_mem[idx][31:16] = wd;
        else         model_mem[idx][15:0]  = wd;
        return {1'b0, 64'h0};
    endfunction

    // driver: present one request, return at the negedge after the accept edge
    task automatic accept_req(input logic rw, input logic [31:0] addr, input logic [15:0] wd);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 65'(req_ready), 65'd1);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        acc_time = $time;
        @(negedge clk);
        req_valid = 1'b0;
        req_rw    = ~rw;
        req_addr  = $urandom;
        req_wdata = 16'($urandom_range(0, 65535));
    endtask

    task automatic do_req(input logic rw, input logic [31:0] addr, input logic [15:0] wd);
        exp_q.push_back(model_apply(rw, addr, wd));
        if (rw) rd_count++;
        else    wr_count++;
        accept_req(rw, addr, wd);
    endtask

    // scoreboard side: wait for the response, compare, optionally stall, handshake
    task automatic wait_rsp(input string tag, input int stall, input bit chk_lat);
        int          n = 0;
        logic [64:0] exp;
        rsp_ready = (stall == 0);
        while (!rsp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 65'(rsp_valid), 65'd1);
        if (chk_lat) check({tag, "_latency"}, 65'(($time - 5 - acc_time) / 10), 65'(LATENCY));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
        check({tag, "_data"}, {rsp_err, rsp_rdata}, exp);
        check({tag, "_req_ready_busy"}, 65'(req_ready), 65'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 65'(rsp_valid), 65'd1);
            check({tag, "_hold_data"}, {rsp_err, rsp_rdata}, exp);
            check({tag, "_hold_req_ready"}, 65'(req_ready), 65'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, 65'(rsp_valid), 65'd0);
        check({tag, "_back_idle"}, 65'(req_ready), 65'd1);
    endtask

    initial begin
        int   n;
        time  t1;
        logic [31:0] a;
        logic [15:0] d;
`ifdef MEM_FILL_STATS_EN
        logic [31:0] stall0;
`endif
        rst       = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_state", 65'(state), 65'(IDLE));
        check("rst_req_ready", 65'(req_ready), 65'd1);
        check("rst_rsp_valid", 65'(rsp_valid), 65'd0);
        check("rst_rsp_data", {rsp_err, rsp_rdata}, 65'h0);
        rst = 1'b0;

        // preload mem[8..9] and mem[1022..1023] through the write path
        do_req(WRITE, 32'h20, 16'h1111);   wait_rsp("pre0", 0, 1);
        do_req(WRITE, 32'h22, 16'h1111);   wait_rsp("pre1", 0, 1);
        do_req(WRITE, 32'h24, 16'h2222);   wait_rsp("pre2", 0, 1);
        do_req(WRITE, 32'h26, 16'h2222);   wait_rsp("pre3", 0, 1);
        do_req(WRITE, 32'hFF8, 16'hAAAA);  wait_rsp("pre4", 0, 1);
        do_req(WRITE, 32'hFFA, 16'hBBBB);  wait_rsp("pre5", 0, 1);
        do_req(WRITE, 32'hFFC, 16'hCCCC);  wait_rsp("pre6", 0, 1);
        do_req(WRITE, 32'hFFE, 16'hDDDD);  wait_rsp("pre7", 0, 1);

        do_req(READ, 32'h20, 16'h0);       wait_rsp("rd_basic", 0, 1);
        do_req(WRITE, 32'h26, 16'hBEEF);   wait_rsp("wr_beef", 0, 1);
        do_req(READ, 32'h20, 16'h0);       wait_rsp("rd_beef", 0, 1);
        do_req(WRITE, 32'h23, 16'h5555);   wait_rsp("wr_odd", 0, 1);
        do_req(READ, 32'h27, 16'h0);       wait_rsp("rd_unaligned", 0, 1);

`ifdef MEM_FILL_STATS_EN
        stall0 = stat_stall;
`endif
        do_req(READ, 32'h20, 16'h0);       wait_rsp("rd_stall", 5, 1);
`ifdef MEM_FILL_STATS_EN
        check("stat_stall", 65'(stat_stall - stall0), 65'd5);
`endif

        do_req(READ, 32'hFF8, 16'h0);      wait_rsp("rd_top", 0, 1);
        do_req(READ, 32'h1FF8, 16'h0);     wait_rsp("rd_oob", 0, 1);
        do_req(WRITE, 32'h1000, 16'h5A5A); wait_rsp("wr_oob", 0, 1);
        do_req(READ, 32'hFF8, 16'h0);      wait_rsp("rd_top_again", 0, 1);

        // back-to-back reads with req_valid held high
        exp_q.push_back(model_apply(READ, 32'h20, 16'h0));
        exp_q.push_back(model_apply(READ, 32'hFF8, 16'h0));
        rd_count += 2;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_rw    = READ;
        req_addr  = 32'h20;
        @(posedge clk);
        t1 = $time;
        @(negedge clk);
        req_addr = 32'hFF8;
        n = 0;
        while (n < 40) begin
            if (rsp_valid) check("b2b_first_data", {rsp_err, rsp_rdata}, exp_q.pop_front());
            if (req_ready) break;
            @(negedge clk);
            n++;
        end
        check("b2b_ready", 65'(req_ready), 65'd1);
        @(posedge clk);
        acc_time = $time;
        check("b2b_gap", 65'((acc_time - t1) / 10), 65'(LATENCY + 2));
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp("b2b_second", 0, 1);

        // reset two cycles into a write: transaction must vanish
        accept_req(WRITE, 32'h20, 16'hDEAD);
        @(posedge clk);
        #2 rst = 1'b1;
        rd_count = 0;
        wr_count = 0;
        @(negedge clk);
        check("wr_rst_state", 65'(state), 65'(IDLE));
        check("wr_rst_rsp_valid", 65'(rsp_valid), 65'd0);
        check("wr_rst_req_ready", 65'(req_ready), 65'd1);
        check("wr_rst_data", {rsp_err, rsp_rdata}, 65'h0);
        repeat (4) @(negedge clk);
        check("wr_rst_still_idle", 65'(rsp_valid), 65'd0);
        rst = 1'b0;
        do_req(READ, 32'h20, 16'h0);       wait_rsp("rd_after_rst", 0, 1);

        // random mix over the initialised blocks
        for (int i = 0; i < 8; i++) begin
            a = ($urandom_range(0, 1) != 0) ? 32'h20 : 32'hFF8;
            a = a + 32'($urandom_range(0, 7));
            d = 16'($urandom_range(0, 65535));
            do_req(WRITE, a, d);           wait_rsp("rnd_wr", 0, 1);
            a = ($urandom_range(0, 1) != 0) ? 32'h20 : 32'hFF8;
            do_req(READ, a + 32'($urandom_range(0, 7)), 16'h0);
            wait_rsp("rnd_rd", $urandom_range(0, 2), 1);
        end

`ifdef MEM_FILL_STATS_EN
        check("stat_reads", 65'(stat_reads), 65'(rd_count));
        check("stat_writes", 65'(stat_writes), 65'(wr_count));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
